fadder_iterative: RTL and testbench

FADDER_ITERATIVE -- requirements
Module: fadder_iterative

---
 rtl/fadder_iterative.sv | 255 +++++++++++++++++++++++++
 tb/tb_fadder_iterative.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadder_iterative.sv
// Iterative floating-point adder/subtractor: one-bit-per-cycle alignment and
// normalization behind a valid/ready handshake on both sides.
module fadder_iterative #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic             in_Clk,
  input  logic             in_Reset_N,
  input  logic             in_Valid,
  output logic             out_InReady,
  input  logic             in_Sub,
  input  logic             in_Sign_1,
  input  logic [EXP_W-1:0] in_Exponent_1,
  input  logic [MAN_W-1:0] in_Mantissa_1,
  input  logic             in_Sign_2,
  input  logic [EXP_W-1:0] in_Exponent_2,
  input  logic [MAN_W-1:0] in_Mantissa_2,
  output logic             out_Valid,
  input  logic             in_OutReady,
  output logic             out_Sign,
  output logic [EXP_W-1:0] out_Exponent,
  output logic [MAN_W-1:0] out_Mantissa,
  output logic             out_Overflow,
  output logic             out_Underflow,
  output logic             out_Invalid
);

  localparam int WW    = MAN_W + 4;
  localparam int SW    = MAN_W + 5;
  localparam int CNT_W = $clog2(MAN_W + 5);
  localparam logic [EXP_W-1:0] EXP_MAX = '1;
  localparam logic [MAN_W-1:0] NAN_MAN = {1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [WW-1:0]    bigMan_q, bigMan_d;
  logic [WW-1:0]    smallMan_q, smallMan_d;
  logic             bigSign_q, bigSign_d;
  logic             smallSign_q, smallSign_d;
  logic [SW-1:0]    sum_q, sum_d;
  logic             resSign_q, resSign_d;
  logic [EXP_W-1:0] resExp_q, resExp_d;
  logic [MAN_W-1:0] resMan_q, resMan_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             inv_q, inv_d;

  logic             sign2Eff;
  logic             zero1, zero2, nan1, nan2, inf1, inf2;
  logic             isNan, isSpecial;
  logic             specSign;
  logic [EXP_W-1:0] specExp;
  logic [MAN_W-1:0] specMan;
  logic             op1Big;
  logic [EXP_W-1:0] expDiff;
  logic [31:0]      diffWide;
  logic [CNT_W-1:0] alignCnt;
  logic [WW-1:0]    man1Ext, man2Ext;

  // Operand classification on the raw inputs, evaluated at the accept edge.
  assign sign2Eff = in_Sign_2 ^ in_Sub;
  assign zero1    = (in_Exponent_1 == '0);
  assign zero2    = (in_Exponent_2 == '0);
  assign nan1     = (in_Exponent_1 == EXP_MAX) && (in_Mantissa_1 != '0);
  assign nan2     = (in_Exponent_2 == EXP_MAX) && (in_Mantissa_2 != '0);
  assign inf1     = (in_Exponent_1 == EXP_MAX) && (in_Mantissa_1 == '0);
  assign inf2     = (in_Exponent_2 == EXP_MAX) && (in_Mantissa_2 == '0);
  assign isNan    = nan1 || nan2 || (inf1 && inf2 && (in_Sign_1 != sign2Eff));
  assign isSpecial = isNan || inf1 || inf2 || zero1 || zero2;

  assign op1Big   = (in_Exponent_1 >= in_Exponent_2);
  assign expDiff  = op1Big ? (in_Exponent_1 - in_Exponent_2) : (in_Exponent_2 - in_Exponent_1);
  assign diffWide = 32'(expDiff);
  assign alignCnt = (diffWide > 32'(WW)) ? CNT_W'(WW) : CNT_W'(diffWide);
  assign man1Ext  = {1'b1, in_Mantissa_1, 3'b000};
  assign man2Ext  = {1'b1, in_Mantissa_2, 3'b000};

  always_comb begin
    specSign = 1'b0;
    specExp  = '0;
    specMan  = '0;
    if (isNan) begin
      specExp = EXP_MAX;
      specMan = NAN_MAN;
    end else if (inf1) begin
      specSign = in_Sign_1;
      specExp  = EXP_MAX;
    end else if (inf2) begin
      specSign = sign2Eff;
      specExp  = EXP_MAX;
    end else if (zero1 && zero2) begin
      specSign = in_Sign_1 & sign2Eff;
    end else if (zero1) begin
      specSign = sign2Eff;
      specExp  = in_Exponent_2;
      specMan  = in_Mantissa_2;
    end else if (zero2) begin
      specSign = in_Sign_1;
      specExp  = in_Exponent_1;
      specMan  = in_Mantissa_1;
    end
  end

  always_ff @(posedge in_Clk or negedge in_Reset_N) begin
    if (!in_Reset_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      exp_q       <= '0;
      bigMan_q    <= '0;
      smallMan_q  <= '0;
      bigSign_q   <= 1'b0;
      smallSign_q <= 1'b0;
      sum_q       <= '0;
      resSign_q   <= 1'b0;
      resExp_q    <= '0;
      resMan_q    <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      exp_q       <= exp_d;
      bigMan_q    <= bigMan_d;
      smallMan_q  <= smallMan_d;
      bigSign_q   <= bigSign_d;
      smallSign_q <= smallSign_d;
      sum_q       <= sum_d;
      resSign_q   <= resSign_d;
      resExp_q    <= resExp_d;
      resMan_q    <= resMan_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      inv_q       <= inv_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    exp_d       = exp_q;
    bigMan_d    = bigMan_q;
    smallMan_d  = smallMan_q;
    bigSign_d   = bigSign_q;
    smallSign_d = smallSign_q;
    sum_d       = sum_q;
    resSign_d   = resSign_q;
    resExp_d    = resExp_q;
    resMan_d    = resMan_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    inv_d       = inv_q;

    case (state_q)
      IDLE: begin
        if (in_Valid) begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
          inv_d = 1'b0;
          if (isSpecial) begin
            state_d   = DONE;
            resSign_d = specSign;
            resExp_d  = specExp;
            resMan_d  = specMan;
            inv_d     = isNan;
          end else begin
            // Equal exponents keep op1 as the unshifted operand.
            state_d     = ALIGN;
            cnt_d       = alignCnt;
            exp_d       = op1Big ? in_Exponent_1 : in_Exponent_2;
            bigMan_d    = op1Big ? man1Ext : man2Ext;
            smallMan_d  = op1Big ? man2Ext : man1Ext;
            bigSign_d   = op1Big ? in_Sign_1 : sign2Eff;
            smallSign_d = op1Big ? sign2Eff : in_Sign_1;
          end
        end
      end

      ALIGN: begin
        if (cnt_q != '0) begin
          smallMan_d = smallMan_q >> 1;
          cnt_d      = cnt_q - CNT_W'(1);
        end else begin
          state_d = ADD;
        end
      end

      ADD: begin
        state_d = NORM;
        if (bigSign_q == smallSign_q) begin
          sum_d     = {1'b0, bigMan_q} + {1'b0, smallMan_q};
          resSign_d = bigSign_q;
        end else if (bigMan_q >= smallMan_q) begin
          sum_d     = {1'b0, bigMan_q} - {1'b0, smallMan_q};
          resSign_d = bigSign_q;
        end else begin
          sum_d     = {1'b0, smallMan_q} - {1'b0, bigMan_q};
          resSign_d = smallSign_q;
        end
      end

      NORM: begin
        // Range checks come before shifting so a saturating step costs one extra cycle.
        if (sum_q == '0) begin
          state_d   = DONE;
          resSign_d = 1'b0;
          resExp_d  = '0;
          resMan_d  = '0;
        end else if (exp_q == EXP_MAX) begin
          state_d  = DONE;
          resExp_d = EXP_MAX;
          resMan_d = '0;
          ovf_d    = 1'b1;
        end else if (exp_q == '0) begin
          state_d   = DONE;
          resSign_d = 1'b0;
          resExp_d  = '0;
          resMan_d  = '0;
          unf_d     = 1'b1;
        end else if (sum_q[SW-1]) begin
          sum_d = sum_q >> 1;
          exp_d = exp_q + EXP_W'(1);
        end else if (!sum_q[WW-1]) begin
          sum_d = sum_q << 1;
          exp_d = exp_q - EXP_W'(1);
        end else begin
          state_d  = DONE;
          resExp_d = exp_q;
          resMan_d = sum_q[WW-2:3];
        end
      end

      DONE: begin
        if (in_OutReady) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign out_InReady   = (state_q == IDLE);
  assign out_Valid     = (state_q == DONE);
  assign out_Sign      = out_Valid & resSign_q;
  assign out_Exponent  = out_Valid ? resExp_q : '0;
  assign out_Mantissa  = out_Valid ? resMan_q : '0;
  assign out_Overflow  = out_Valid & ovf_q;
  assign out_Underflow = out_Valid & unf_q;
  assign out_Invalid   = out_Valid & inv_q;

endmodule

// File: tb/tb_fadder_iterative.sv
// Directed bench for fadder_iterative: an arithmetic reference model checked
// every cycle, plus hand-computed results and latencies for each vector.
module tb_fadder_iterative;

  typedef struct packed {
    logic       s;
    logic [4:0] e;
    logic [9:0] m;
    logic       ovf;
    logic       unf;
    logic       inv;
  } res_t;

  logic       in_Clk = 1'b0;
  logic       in_Reset_N = 1'b0;
  logic       in_Valid = 1'b0;
  logic       in_Sub = 1'b0;
  logic       in_Sign_1 = 1'b0;
  logic [4:0] in_Exponent_1 = '0;
  logic [9:0] in_Mantissa_1 = '0;
  logic       in_Sign_2 = 1'b0;
  logic [4:0] in_Exponent_2 = '0;
  logic [9:0] in_Mantissa_2 = '0;
  logic       in_OutReady = 1'b0;
  logic       out_InReady, out_Valid, out_Sign;
  logic [4:0] out_Exponent;
  logic [9:0] out_Mantissa;
  logic       out_Overflow, out_Underflow, out_Invalid;

  int   nCompared = 0;
  int   nMismatched = 0;
  int   cycle = 0;
  res_t expRes = '0;
  int   expLat = 0;
  logic expPending = 1'b0;
  logic firstSeen = 1'b0;
  int   acceptCycle = 0;
  res_t gotRes = '0;
  int   gotLat = 0;
  res_t dutNow;

  fadder_iterative #(.EXP_W(5), .MAN_W(10)) dut (
    .in_Clk(in_Clk), .in_Reset_N(in_Reset_N), .in_Valid(in_Valid), .out_InReady(out_InReady),
    .in_Sub(in_Sub), .in_Sign_1(in_Sign_1), .in_Exponent_1(in_Exponent_1), .in_Mantissa_1(in_Mantissa_1),
    .in_Sign_2(in_Sign_2), .in_Exponent_2(in_Exponent_2), .in_Mantissa_2(in_Mantissa_2),
    .out_Valid(out_Valid), .in_OutReady(in_OutReady), .out_Sign(out_Sign),
    .out_Exponent(out_Exponent), .out_Mantissa(out_Mantissa), .out_Overflow(out_Overflow),
    .out_Underflow(out_Underflow), .out_Invalid(out_Invalid)
  );

  assign dutNow = {out_Sign, out_Exponent, out_Mantissa, out_Overflow, out_Underflow, out_Invalid};

  always #5 in_Clk = ~in_Clk;
  always @(posedge in_Clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, want %h (cycle %0d)", name, got, want, cycle);
    end
  endtask

  function automatic res_t mk(input logic s, input logic [4:0] e, input logic [9:0] m,
                              input logic o, input logic u, input logic i);
    return {s, e, m, o, u, i};
  endfunction

  // Reference: exact integer significands scaled by 8 (three guard bits), truncating shifts.
  function automatic void model(input logic sub, input logic s1, input logic [4:0] e1, input logic [9:0] m1,
                                input logic s2r, input logic [4:0] e2, input logic [9:0] m2,
                                output res_t r, output int lat);
    logic s2, nan1, nan2, inf1, inf2, sb, ss, sr;
    int   eb, es, d, mb, ms, mag, n;
    s2   = s2r ^ sub;
    nan1 = (e1 == 5'd31) && (m1 != 10'd0);
    nan2 = (e2 == 5'd31) && (m2 != 10'd0);
    inf1 = (e1 == 5'd31) && (m1 == 10'd0);
    inf2 = (e2 == 5'd31) && (m2 == 10'd0);
    lat  = 0;
    r    = '0;
    if (nan1 || nan2 || (inf1 && inf2 && (s1 != s2))) r = mk(1'b0, 5'd31, 10'h200, 1'b0, 1'b0, 1'b1);
    else if (inf1) r = mk(s1, 5'd31, 10'd0, 1'b0, 1'b0, 1'b0);
    else if (inf2) r = mk(s2, 5'd31, 10'd0, 1'b0, 1'b0, 1'b0);
    else if (e1 == 5'd0 && e2 == 5'd0) r = mk(s1 & s2, 5'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    else if (e1 == 5'd0) r = mk(s2, e2, m2, 1'b0, 1'b0, 1'b0);
    else if (e2 == 5'd0) r = mk(s1, e1, m1, 1'b0, 1'b0, 1'b0);
    else begin
      if (e1 >= e2) begin
        eb = int'(e1); es = int'(e2); sb = s1; ss = s2;
        mb = (1024 + int'(m1)) * 8; ms = (1024 + int'(m2)) * 8;
      end else begin
        eb = int'(e2); es = int'(e1); sb = s2; ss = s1;
        mb = (1024 + int'(m2)) * 8; ms = (1024 + int'(m1)) * 8;
      end
      d = eb - es;
      if (d > 14) d = 14;
      ms = ms >> d;
      if (sb == ss) begin mag = mb + ms; sr = sb; end
      else if (mb >= ms) begin mag = mb - ms; sr = sb; end
      else begin mag = ms - mb; sr = ss; end
      n = 0;
      if (mag == 0) begin
        r = '0;
      end else if (mag >= 16384) begin
        n = 1;
        mag = mag / 2;
        if (eb + 1 == 31) r = mk(sr, 5'd31, 10'd0, 1'b1, 1'b0, 1'b0);
        else r = mk(sr, 5'(eb + 1), 10'((mag / 8) % 1024), 1'b0, 1'b0, 1'b0);
      end else begin
        while (mag < 8192) begin mag = mag * 2; n++; end
        if (eb - n <= 0) begin
          n = eb;
          r = mk(1'b0, 5'd0, 10'd0, 1'b0, 1'b1, 1'b0);
        end else begin
          r = mk(sr, 5'(eb - n), 10'((mag / 8) % 1024), 1'b0, 1'b0, 1'b0);
        end
      end
      lat = d + n + 3;
    end
  endfunction

  // Every cycle: a valid result must match the model; otherwise the flags must be low.
  always @(negedge in_Clk) begin
    if (out_Valid) begin
      if (!expPending) begin
        check("unexpectedValid", 32'(out_Valid), 32'd0);
      end else begin
        check("modelResult", 32'(dutNow), 32'(expRes));
        if (!firstSeen) begin
          firstSeen = 1'b1;
          check("modelLatency", 32'(cycle - acceptCycle), 32'(expLat));
        end
      end
    end else begin
      check("flagsIdle", 32'({out_Overflow, out_Underflow, out_Invalid}), 32'd0);
    end
  end

  task automatic startOp(input logic sub, input logic s1, input logic [4:0] e1, input logic [9:0] m1,
                         input logic s2, input logic [4:0] e2, input logic [9:0] m2);
    @(negedge in_Clk);
    check("inReadyBeforeAccept", 32'(out_InReady), 32'd1);
    in_Sub = sub; in_Sign_1 = s1; in_Exponent_1 = e1; in_Mantissa_1 = m1;
    in_Sign_2 = s2; in_Exponent_2 = e2; in_Mantissa_2 = m2;
    in_Valid = 1'b1; in_OutReady = 1'b0;
    model(sub, s1, e1, m1, s2, e2, m2, expRes, expLat);
    firstSeen = 1'b0; expPending = 1'b1; acceptCycle = cycle + 1;
    @(negedge in_Clk);
    in_Valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic sub, input logic s1, input logic [4:0] e1, input logic [9:0] m1,
                               input logic s2, input logic [4:0] e2, input logic [9:0] m2, input int hold);
    int waitCnt;
    startOp(sub, s1, e1, m1, s2, e2, m2);
    waitCnt = 0;
    while (!out_Valid && waitCnt < 100) begin
      @(negedge in_Clk);
      waitCnt++;
    end
    if (!out_Valid) begin
      check("validTimeout", 32'(out_Valid), 32'd1);
      expPending = 1'b0;
      return;
    end
    gotRes = dutNow;
    gotLat = cycle - acceptCycle;
    for (int i = 0; i < hold; i++) begin
      in_Valid = 1'b1; in_Sign_1 = ~s1; in_Exponent_1 = e1 ^ 5'h3; in_Mantissa_1 = ~m1;
      in_OutReady = 1'b0;
      @(negedge in_Clk);
      check("holdStable", 32'(dutNow), 32'(gotRes));
      check("holdInReady", 32'(out_InReady), 32'd0);
    end
    in_OutReady = 1'b1;
    @(posedge in_Clk);
    @(negedge in_Clk);
    in_OutReady = 1'b0; in_Valid = 1'b0; expPending = 1'b0;
    check("releasedValid", 32'(out_Valid), 32'd0);
    check("releasedInReady", 32'(out_InReady), 32'd1);
  endtask

  task automatic checkOutput(input string name, input res_t want, input int wantLat);
    check({name, "/result"}, 32'(gotRes), 32'(want));
    check({name, "/latency"}, 32'(gotLat), 32'(wantLat));
  endtask

  task automatic resetNow();
    #2 in_Reset_N = 1'b0;
    expPending = 1'b0;
    #1;
    check("rstOutputs", 32'(dutNow), 32'd0);
    check("rstInReady", 32'(out_InReady), 32'd1);
    check("rstValid", 32'(out_Valid), 32'd0);
    @(posedge in_Clk);
    #1 in_Reset_N = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(negedge in_Clk);
    check("resetOutputs", 32'(dutNow), 32'd0);
    check("resetInReady", 32'(out_InReady), 32'd1);
    @(posedge in_Clk);
    #1 in_Reset_N = 1'b1;

    applyStimulus(1'b0, 1'b1, 5'd18, 10'h220, 1'b1, 5'd16, 10'h0A0, 0);
    checkOutput("neg12p25PlusNeg2p3125", mk(1'b1, 5'd18, 10'h348, 1'b0, 1'b0, 1'b0), 5);
    applyStimulus(1'b1, 1'b0, 5'd15, 10'h000, 1'b0, 5'd14, 10'h200, 0);
    checkOutput("oneMinus0p75", mk(1'b0, 5'd13, 10'h000, 1'b0, 1'b0, 1'b0), 6);
    applyStimulus(1'b1, 1'b0, 5'd15, 10'h000, 1'b0, 5'd15, 10'h000, 0);
    checkOutput("cancel", mk(1'b0, 5'd0, 10'h000, 1'b0, 1'b0, 1'b0), 3);
    applyStimulus(1'b0, 1'b0, 5'd30, 10'h3FF, 1'b0, 5'd30, 10'h3FF, 0);
    checkOutput("overflow", mk(1'b0, 5'd31, 10'h000, 1'b1, 1'b0, 1'b0), 4);
    applyStimulus(1'b0, 1'b0, 5'd31, 10'h000, 1'b1, 5'd31, 10'h000, 0);
    checkOutput("infMinusInf", mk(1'b0, 5'd31, 10'h200, 1'b0, 1'b0, 1'b1), 0);
    applyStimulus(1'b0, 1'b0, 5'd30, 10'h000, 1'b0, 5'd1, 10'h000, 0);
    checkOutput("gap29", mk(1'b0, 5'd30, 10'h000, 1'b0, 1'b0, 1'b0), 17);
    applyStimulus(1'b1, 1'b0, 5'd0, 10'h155, 1'b1, 5'd20, 10'h0F0, 0);
    checkOutput("zeroMinusNeg", mk(1'b0, 5'd20, 10'h0F0, 1'b0, 1'b0, 1'b0), 0);
    applyStimulus(1'b0, 1'b1, 5'd0, 10'h000, 1'b1, 5'd0, 10'h000, 0);
    checkOutput("negZeroPlusNegZero", mk(1'b1, 5'd0, 10'h000, 1'b0, 1'b0, 1'b0), 0);
    applyStimulus(1'b1, 1'b1, 5'd0, 10'h000, 1'b1, 5'd0, 10'h000, 0);
    checkOutput("negZeroMinusNegZero", mk(1'b0, 5'd0, 10'h000, 1'b0, 1'b0, 1'b0), 0);
    applyStimulus(1'b0, 1'b0, 5'd31, 10'h001, 1'b0, 5'd3, 10'h000, 0);
    checkOutput("nanOperand", mk(1'b0, 5'd31, 10'h200, 1'b0, 1'b0, 1'b1), 0);
    applyStimulus(1'b0, 1'b1, 5'd31, 10'h000, 1'b0, 5'd10, 10'h005, 0);
    checkOutput("singleInf", mk(1'b1, 5'd31, 10'h000, 1'b0, 1'b0, 1'b0), 0);
    applyStimulus(1'b1, 1'b0, 5'd1, 10'h001, 1'b0, 5'd1, 10'h000, 0);
    checkOutput("underflow", mk(1'b0, 5'd0, 10'h000, 1'b0, 1'b1, 1'b0), 4);
    applyStimulus(1'b1, 1'b0, 5'd14, 10'h200, 1'b0, 5'd15, 10'h000, 0);
    checkOutput("op2Larger", mk(1'b1, 5'd13, 10'h000, 1'b0, 1'b0, 1'b0), 6);
    applyStimulus(1'b0, 1'b0, 5'd15, 10'h3FF, 1'b0, 5'd15, 10'h3FF, 0);
    checkOutput("carryTruncate", mk(1'b0, 5'd16, 10'h3FF, 1'b0, 1'b0, 1'b0), 4);

    applyStimulus(1'b0, 1'b1, 5'd18, 10'h220, 1'b1, 5'd16, 10'h0A0, 3);
    checkOutput("backpressure", mk(1'b1, 5'd18, 10'h348, 1'b0, 1'b0, 1'b0), 5);

    startOp(1'b0, 1'b0, 5'd30, 10'h000, 1'b0, 5'd1, 10'h000);
    @(negedge in_Clk);
    check("alignBusy", 32'(out_InReady), 32'd0);
    resetNow();
    applyStimulus(1'b0, 1'b1, 5'd18, 10'h220, 1'b1, 5'd16, 10'h0A0, 0);
    checkOutput("afterAlignReset", mk(1'b1, 5'd18, 10'h348, 1'b0, 1'b0, 1'b0), 5);

    startOp(1'b0, 1'b0, 5'd31, 10'h001, 1'b0, 5'd3, 10'h000);
    check("doneBeforeReset", 32'(out_Valid), 32'd1);
    resetNow();
    applyStimulus(1'b1, 1'b0, 5'd15, 10'h000, 1'b0, 5'd14, 10'h200, 0);
    checkOutput("afterDoneReset", mk(1'b0, 5'd13, 10'h000, 1'b0, 1'b0, 1'b0), 6);

    repeat (2) @(negedge in_Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
